// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit producing the Hi/Lo pair for
// mult, multu, div and divu. One shift-add (multiply) or restoring-subtract
// (divide) step is performed per clock over a 2*WIDTH+1 bit accumulator that
// works on operand magnitudes; signs are applied in a final FIX cycle.
//
// Optional feature macro: MUL_DIV_FAST_ZERO_EN
//   When defined, an operation whose latched busA or busB is zero skips the
//   iteration phase and goes straight from IDLE to FIX.
//   When undefined, every operation runs the full WIDTH iterations.

module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MdOp,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             DivZero
);

    localparam int AW = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  iterOp_q;
    logic [WIDTH-1:0]  rawA_q;
    logic              negQ_q;
    logic              negR_q;
    logic [AW-1:0]     acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              divZero_q;
`ifdef MUL_DIV_FAST_ZERO_EN
    logic              zeroFast_q;
`endif

    // Operand preparation: magnitudes and result signs taken from the live inputs
    logic              isSigned;
    logic              signA;
    logic              signB;
    logic [WIDTH-1:0]  magA;
    logic [WIDTH-1:0]  magB;
    logic [AW-1:0]     accInit_d;
    logic [WIDTH-1:0]  iterOpInit_d;

    // Derive operand magnitudes and the starting accumulator for an accepted Start
    always_comb begin
        isSigned     = MdOp[0];
        signA        = isSigned & busA[WIDTH-1];
        signB        = isSigned & busB[WIDTH-1];
        magA         = signA ? (-busA) : busA;
        magB         = signB ? (-busB) : busB;
        accInit_d    = '0;
        iterOpInit_d = '0;
        if (MdOp[1]) begin
            accInit_d    = {{(WIDTH+1){1'b0}}, magA};
            iterOpInit_d = magB;
        end else begin
            accInit_d    = {{(WIDTH+1){1'b0}}, magB};
            iterOpInit_d = magA;
        end
    end

    // Iteration step logic
    logic [WIDTH:0]    mulSum;
    logic [AW-1:0]     mulStep;
    logic [AW-1:0]     divShift;
    logic [WIDTH+1:0]  divDiff;
    logic [AW-1:0]     divStep;
    logic [AW-1:0]     accStep_d;

    // One shift-add or restoring-subtract step of the active operation
    always_comb begin
        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, iterOp_q};
        mulStep  = acc_q[0] ? {1'b0, mulSum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[AW-1:1]};
        divShift = {acc_q[AW-2:0], 1'b0};
        divDiff  = {1'b0, divShift[AW-1:WIDTH]} - {2'b00, iterOp_q};
        divStep  = divDiff[WIDTH+1] ? divShift
                                    : {divDiff[WIDTH:0], divShift[WIDTH-1:1], 1'b1};
        accStep_d = op_q[1] ? divStep : mulStep;
    end

    // Sign fix-up and final result selection
    logic [2*WIDTH-1:0] prodMag;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotMag;
    logic [WIDTH-1:0]   remMag;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;
    logic               divByZero;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    // Apply two's-complement negation and pick the Hi/Lo values written in FIX
    always_comb begin
        prodMag   = acc_q[2*WIDTH-1:0];
        prodFix   = negQ_q ? (-prodMag) : prodMag;
        quotMag   = acc_q[WIDTH-1:0];
        remMag    = acc_q[2*WIDTH-1:WIDTH];
        quotFix   = negQ_q ? (-quotMag) : quotMag;
        remFix    = negR_q ? (-remMag) : remMag;
        divByZero = op_q[1] && (iterOp_q == '0);
        hi_d      = prodFix[2*WIDTH-1:WIDTH];
        lo_d      = prodFix[WIDTH-1:0];
        if (divByZero) begin
            hi_d = rawA_q;
            lo_d = {WIDTH{1'b1}};
        end else if (op_q[1]) begin
            hi_d = remFix;
            lo_d = quotFix;
        end
`ifdef MUL_DIV_FAST_ZERO_EN
        if (zeroFast_q && !divByZero) begin
            hi_d = '0;
            lo_d = '0;
        end
`endif
    end

`ifdef MUL_DIV_FAST_ZERO_EN
    logic zeroOperand;

    // A zero operand lets the operation bypass the iteration phase
    always_comb begin
        zeroOperand = (busA == '0) || (busB == '0);
    end
`endif

    // Control FSM and datapath registers; outputs are all registered
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            iterOp_q   <= '0;
            rawA_q     <= '0;
            negQ_q     <= 1'b0;
            negR_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            divZero_q  <= 1'b0;
`ifdef MUL_DIV_FAST_ZERO_EN
            zeroFast_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        op_q      <= MdOp;
                        iterOp_q  <= iterOpInit_d;
                        rawA_q    <= busA;
                        negQ_q    <= signA ^ signB;
                        negR_q    <= signA;
                        acc_q     <= accInit_d;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        divZero_q <= 1'b0;
                        state_q   <= CALC;
`ifdef MUL_DIV_FAST_ZERO_EN
                        zeroFast_q <= zeroOperand;
                        if (zeroOperand) begin
                            state_q <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    acc_q <= accStep_d;
                    cnt_q <= cnt_q + CntOne;
                    if (cnt_q == CntLast) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q      <= hi_d;
                    lo_q      <= lo_d;
                    divZero_q <= divByZero;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign HiOut   = hi_q;
    assign LoOut   = lo_q;
    assign DivZero = divZero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an
// arithmetic reference model (64-bit products, language-level / and %).

module tb_mul_div_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  MdOp;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        Busy;
    logic        Done;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        DivZero;

    int checks   = 0;
    int failures = 0;

    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .MdOp    (MdOp),
        .busA    (busA),
        .busB    (busB),
        .Busy    (Busy),
        .Done    (Done),
        .HiOut   (HiOut),
        .LoOut   (LoOut),
        .DivZero (DivZero)
    );

    // Free-running clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Runaway guard
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: Hi/Lo/DivZero from plain arithmetic
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo, output logic dz);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (op)
            2'b00: begin
                p  = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                    dz = 1'b1;
                end else if (op == 2'b10) begin
                    hi = a % b;
                    lo = a / b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = 64'(q);
                    lo = p[31:0];
                    p  = 64'(r);
                    hi = p[31:0];
                end
            end
        endcase
    endfunction

    // Expected number of cycles from acceptance to the Done cycle
    function automatic int refLatency(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_DIV_FAST_ZERO_EN
        if (a == 32'h0 || b == 32'h0) return 2;
`endif
        return 34;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally re-pulse Start mid-flight or in the Done cycle
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int repulseAt, input bit pulseInDone);
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expDz;
        int          expLat;
        int          cycle;
        int          doneAt;
        int          holdBad;
        refModel(op, a, b, expHi, expLo, expDz);
        expLat = refLatency(a, b);
        @(negedge Clk);
        Start = 1'b1;
        MdOp  = op;
        busA  = a;
        busB  = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        MdOp  = 2'($urandom);
        busA  = $urandom;
        busB  = $urandom;
        cycle   = 0;
        doneAt  = 0;
        holdBad = 0;
        while (doneAt == 0 && cycle < 60) begin
            @(negedge Clk);
            cycle++;
            if (Done === 1'b1) begin
                doneAt = cycle;
            end else if (Busy !== 1'b1 || HiOut !== lastHi || LoOut !== lastLo) begin
                holdBad++;
            end
            if (cycle == repulseAt && doneAt == 0) begin
                Start = 1'b1;
                MdOp  = 2'($urandom);
                busA  = $urandom;
                busB  = $urandom;
                @(posedge Clk);
                #1;
                Start = 1'b0;
            end
        end
        checkOutput({tag, "_latency"}, 64'(doneAt), 64'(expLat));
        checkOutput({tag, "_busyhold"}, 64'(holdBad), 64'd0);
        checkOutput({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
        checkOutput({tag, "_hi"}, 64'(HiOut), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(LoOut), 64'(expLo));
        checkOutput({tag, "_divzero"}, 64'(DivZero), 64'(expDz));
        if (pulseInDone) begin
            Start = 1'b1;
            MdOp  = 2'($urandom);
            busA  = $urandom;
            busB  = $urandom;
            @(posedge Clk);
            #1;
            Start = 1'b0;
        end
        @(negedge Clk);
        checkOutput({tag, "_done_single"}, 64'(Done), 64'd0);
        checkOutput({tag, "_idle_busy"}, 64'(Busy), 64'd0);
        lastHi = expHi;
        lastLo = expLo;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Directed sequence followed by randomized operations
    initial begin
        int sawDone;
        int resetBad;
        Reset = 1'b0;
        Start = 1'b0;
        MdOp  = 2'b00;
        busA  = '0;
        busB  = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("reset_busy", 64'(Busy), 64'd0);
        checkOutput("reset_done", 64'(Done), 64'd0);
        checkOutput("reset_hi", 64'(HiOut), 64'd0);
        checkOutput("reset_lo", 64'(LoOut), 64'd0);
        checkOutput("reset_divzero", 64'(DivZero), 64'd0);

        applyStimulus("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        checkOutput("multu_max_const_hi", 64'(HiOut), 64'h0000_0000_FFFF_FFFE);
        checkOutput("multu_max_const_lo", 64'(LoOut), 64'h0000_0000_0000_0001);
        applyStimulus("mult_neg7x3", 2'b01, 32'hFFFF_FFF9, 32'd3, 0, 1'b0);
        checkOutput("mult_neg7x3_const_lo", 64'(LoOut), 64'h0000_0000_FFFF_FFEB);
        applyStimulus("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        checkOutput("div_neg7by2_const_lo", 64'(LoOut), 64'h0000_0000_FFFF_FFFD);
        applyStimulus("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        applyStimulus("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus("divu_by0", 2'b10, 32'd100, 32'd0, 0, 1'b0);
        applyStimulus("divu_100by7", 2'b10, 32'd100, 32'd7, 0, 1'b0);
        applyStimulus("div_neg_by0", 2'b11, 32'hFFFF_FF00, 32'd0, 0, 1'b0);
        applyStimulus("multu_zero", 2'b00, 32'd0, 32'd12345, 0, 1'b0);
        applyStimulus("div_zero_dividend", 2'b11, 32'd0, 32'hFFFF_FFFD, 0, 1'b0);
        applyStimulus("repulse", 2'b01, 32'h1234_5678, 32'hFEDC_BA98, 10, 1'b1);

        $display("[TB] reset during divide");
        @(negedge Clk);
        Start = 1'b1;
        MdOp  = 2'b11;
        busA  = 32'h7654_3210;
        busB  = 32'h0000_0123;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (15) @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkOutput("midreset_busy", 64'(Busy), 64'd0);
        checkOutput("midreset_done", 64'(Done), 64'd0);
        checkOutput("midreset_hi", 64'(HiOut), 64'd0);
        checkOutput("midreset_lo", 64'(LoOut), 64'd0);
        lastHi = '0;
        lastLo = '0;
        repeat (2) @(negedge Clk);
        Reset    = 1'b1;
        sawDone  = 0;
        resetBad = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done === 1'b1) sawDone++;
            if (HiOut !== 32'h0 || LoOut !== 32'h0 || Busy !== 1'b0) resetBad++;
        end
        checkOutput("midreset_no_done", 64'(sawDone), 64'd0);
        checkOutput("midreset_quiet", 64'(resetBad), 64'd0);
        applyStimulus("after_reset", 2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1'b0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 24; i++) begin
            applyStimulus($sformatf("rand%0d", i), 2'($urandom_range(0, 3)),
                          pickOperand(), pickOperand(), 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit that produces the Hi/Lo pair for mult, multu, div and divu.
- Consumes busA/busB from the register file and drives the HiReg/LoReg write path. The datapath writes Hi and Lo on Done.
- Busy stalls PC/NPC while an operation is in flight.
- Replaces the single-cycle combinational HiRe/LoRe result path.

Parameters:
- WIDTH, 32, operand and result width (Hi and Lo are each WIDTH bits).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request pulse; sampled only in IDLE.
- MdOp  input  2  00=multu, 01=mult, 10=divu, 11=div.
- busA  input  WIDTH  multiplicand / dividend (rs).
- busB  input  WIDTH  multiplier / divisor (rt).
- Busy  output  1  operation in progress; CPU stall request.
- Done  output  1  one-cycle pulse; HiOut/LoOut valid, write HiReg/LoReg.
- HiOut  output  WIDTH  multiply: product[2W-1:W]; divide: remainder.
- LoOut  output  WIDTH  multiply: product[W-1:0]; divide: quotient.
- DivZero  output  1  sticky flag for the last divide: set if the divisor was 0; cleared by the next accepted Start.

Behaviour:
- Reset (Reset=0, async): state=IDLE; Busy=0, Done=0, DivZero=0, HiOut=0, LoOut=0, counter=0. Reset mid-operation aborts it with no Done and no result update.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, Start=1 at edge E0:
  - Latch MdOp.
  - Latch |busA| and |busB| (magnitudes for signed ops; raw values for unsigned).
  - Latch result signs: quotient/product sign = signA^signB; remainder sign = signA.
  - Counter=0; Busy=1 from E0.
- CALC: one iteration per edge, WIDTH iterations (E1..E_WIDTH).
  - Multiply: shift-add over a 2W-bit accumulator, LSB-first multiplier.
  - Divide: restoring divide, 2W-bit remainder/quotient register, MSB-first.
- FIX, edge E_WIDTH+1:
  - Apply two's-complement negation per the latched signs.
  - Register HiOut/LoOut; go to DONE.
- DONE: Done=1 for exactly one cycle; Busy=0 in the same cycle. Next edge returns to IDLE.
- Latency: Done is high in the cycle following edge E_WIDTH+1, i.e. 34 cycles after acceptance for WIDTH=32.
- A new Start is accepted in the DONE cycle's following IDLE cycle, never in DONE.
- Start while Busy=1 or in DONE: ignored; no queuing.
- MdOp/busA/busB changes after E0: no effect.
- HiOut/LoOut hold the last result until the next FIX; they never change while Busy=1.
- Divide by zero: full latency; HiOut=busA (raw dividend), LoOut={WIDTH{1'b1}}, DivZero=1.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: LoOut=0x80000000, HiOut=0. Falls out naturally from the magnitude path; no special case.
- mult of 0x80000000 * 0x80000000: Hi=0x40000000, Lo=0.
- Widths: accumulators are 2*WIDTH+1 bits internally to keep the subtract borrow; outputs are truncated to WIDTH.

Optional Feature:
- Macro: MUL_DIV_FAST_ZERO_EN.
- Defined: if the latched busA==0, or busB==0, go from IDLE straight to FIX, so Done arrives 2 cycles after acceptance.
  - Multiply: results are 0.
  - Divide by zero: same values as above.
  - Divide with dividend 0: Hi=0, Lo=0.
- Undefined: every operation takes the full latency; zero operands follow the normal path.

Test Plan:
- Reset held low 3 cycles, then released -> Busy=0, Done=0, HiOut=0, LoOut=0, DivZero=0.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> Done 34 cycles after Start; HiOut=0xFFFFFFFE, LoOut=0x00000001; Busy high for the 33 preceding cycles.
- mult -7 (0xFFFFFFF9) x 3 -> HiOut=0xFFFFFFFF, LoOut=0xFFFFFFEB. div -7 by 2 -> LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF.
- divu 100 by 0 -> HiOut=100, LoOut=0xFFFFFFFF, DivZero=1 at 34 cycles (2 cycles with MUL_DIV_FAST_ZERO_EN). A following divu 100/7 -> Lo=14, Hi=2, DivZero=0.
- Start re-pulsed with other operands at cycle 10 of a busy op -> ignored; the original result is delivered with a single Done.
- Reset asserted at cycle 15 of a div -> outputs 0 immediately (async), no Done. A fresh Start after release completes normally.
